// File: rtl/des_uart_host.sv
// des_uart_host: sends a 9-byte DES request frame over UART and collects the 8-byte reply for encrypt/decrypt.
// Optional reply timeout: define DES_HOST_TIMEOUT_EN.
module des_uart_host #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int GAP_BITS     = 1,
    parameter int TIMEOUT_BITS = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [63:0] req_data,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic [1:0]  rsp_err,
    output logic        busy,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int BIT_CLKS = CLK_FREQ / BAUD;
    localparam int BW = $clog2(BIT_CLKS + 1);
    localparam int CW = $clog2(TIMEOUT_BITS > 16 ? TIMEOUT_BITS + 1 : 17);
    localparam logic [BW-1:0] BIT_END = BW'(BIT_CLKS - 1);
    localparam logic [BW-1:0] HALF_END = BW'(BIT_CLKS / 2 - 1);
    typedef enum logic [3:0] {
        IDLE, TX_START, TX_BIT, TX_STOP, TX_GAP, RX_WAIT, RX_HALF, RX_BIT, RX_STOP, DONE
    } state_t;
    state_t state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] byte_q, byte_d;
    logic [71:0] frame_q, frame_d;
    logic reply_q, reply_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic [55:0] rx_sr_q, rx_sr_d;
    logic rsp_valid_q, rsp_valid_d, busy_q, busy_d, req_ready_q, req_ready_d, uart_tx_q, uart_tx_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic [1:0] rsp_err_q, rsp_err_d, err;
    logic rx_s1_q, rx_s2_q, rx_s3_q;
    logic bit_end, rx_fall, adv;
    logic [7:0] tx_byte;
    assign bit_end = baud_q == BIT_END;
    assign rx_fall = rx_s3_q && !rx_s2_q;
    // next-state and next-output logic; counters restart on every state change so bytes never drift
    always_comb begin
        state_d = state_q;
        baud_d = baud_q;
        cnt_d = cnt_q;
        byte_d = byte_q;
        frame_d = frame_q;
        reply_d = reply_q;
        rx_byte_d = rx_byte_q;
        rx_sr_d = rx_sr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d = rsp_err_q;
        err = 2'b00;
        adv = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = TX_START;
                frame_d = {req_cmd, req_data};
                reply_d = req_cmd == 8'h0F || req_cmd == 8'hF0;
                byte_d = 4'd0;
            end
            TX_START: if (bit_end) state_d = TX_BIT;
            TX_BIT: if (bit_end) begin
                if (cnt_q == CW'(7)) state_d = TX_STOP;
                else cnt_d = cnt_q + 1'b1;
            end
            TX_STOP: if (bit_end) state_d = TX_GAP;
            TX_GAP: if (bit_end) cnt_d = cnt_q + 1'b1;
            RX_WAIT: begin
                if (rx_fall) state_d = RX_HALF;
`ifdef DES_HOST_TIMEOUT_EN
                else if (bit_end) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(TIMEOUT_BITS - 1)) begin
                        state_d = DONE;
                        err = 2'b10;
                    end
                end
`endif
            end
            RX_HALF: if (baud_q == HALF_END) state_d = rx_s2_q ? RX_WAIT : RX_BIT;
            RX_BIT: if (bit_end) begin
                rx_byte_d = {rx_s2_q, rx_byte_q[7:1]};
                if (cnt_q == CW'(7)) state_d = RX_STOP;
                else cnt_d = cnt_q + 1'b1;
            end
            RX_STOP: if (bit_end) begin
                if (!rx_s2_q) begin
                    state_d = DONE;
                    err = 2'b01;
                end else begin
                    rx_sr_d = {rx_sr_q[47:0], rx_byte_q};
                    state_d = byte_q == 4'd7 ? DONE : RX_WAIT;
                    byte_d = byte_q + 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        adv = bit_end && ((state_q == TX_STOP && GAP_BITS == 0) ||
                          (state_q == TX_GAP && cnt_q == CW'(GAP_BITS - 1)));
        if (adv) begin
            state_d = byte_q == 4'd8 ? (reply_q ? RX_WAIT : DONE) : TX_START;
            byte_d = byte_q == 4'd8 ? 4'd0 : byte_q + 4'd1;
            frame_d = {frame_q[63:0], 8'h00};
        end
        baud_d = (state_d != state_q || bit_end) ? '0 : baud_q + 1'b1;
        if (state_d != state_q) cnt_d = '0;
        if (state_d == DONE) begin
            rsp_err_d = err;
            if (err == 2'b00) rsp_data_d = reply_q ? {rx_sr_q, rx_byte_q} : 64'd0;
        end
        tx_byte = frame_d[71:64];
        uart_tx_d = state_d == TX_START ? 1'b0 : state_d == TX_BIT ? tx_byte[cnt_d[2:0]] : 1'b1;
        rsp_valid_d = state_d == DONE;
        busy_d = state_d != IDLE;
        req_ready_d = state_d == IDLE;
    end
    // all state and registered outputs; reset returns the link to idle with the line high
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q <= '0;
            cnt_q <= '0;
            byte_q <= '0;
            frame_q <= '0;
            reply_q <= 1'b0;
            rx_byte_q <= '0;
            rx_sr_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q <= 2'b00;
            busy_q <= 1'b0;
            req_ready_q <= 1'b1;
            uart_tx_q <= 1'b1;
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q <= baud_d;
            cnt_q <= cnt_d;
            byte_q <= byte_d;
            frame_q <= frame_d;
            reply_q <= reply_d;
            rx_byte_q <= rx_byte_d;
            rx_sr_q <= rx_sr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q <= rsp_err_d;
            busy_q <= busy_d;
            req_ready_q <= req_ready_d;
            uart_tx_q <= uart_tx_d;
            rx_s1_q <= uart_rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err = rsp_err_q;
    assign busy = busy_q;
    assign uart_tx = uart_tx_q;
endmodule

// File: tb/tb_des_uart_host.sv
// tb_des_uart_host: randomized bench with a serial line monitor, a reply responder and a frame-level reference model.
`timescale 1ns/1ps
module tb_des_uart_host;
    localparam int BITC = 16;
    logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, uart_rx = 1'b1;
    logic [7:0] req_cmd = 8'h00;
    logic [63:0] req_data = 64'd0;
    logic req_ready, rsp_valid, busy, uart_tx;
    logic [63:0] rsp_data;
    logic [1:0] rsp_err;
    int checks = 0, errors = 0, cyc = 0, rsp_cnt = 0, rsp_cyc = 0;
    logic [63:0] rsp_d_cap = 64'd0, model_data = 64'd0;
    logic [1:0] rsp_e_cap = 2'b00;
    logic [7:0] tx_q[$];
    int st_q[$];

    des_uart_host #(.CLK_FREQ(16), .BAUD(1), .GAP_BITS(1), .TIMEOUT_BITS(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // cycle counter and response capture, sampled 1ns after each rising edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rsp_valid === 1'b1) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            rsp_d_cap = rsp_data;
            rsp_e_cap = rsp_err;
        end
    end

    // decodes uart_tx into bytes at mid-bit, recording the cycle each start bit began
    initial forever begin : mon
        logic [7:0] b;
        int s;
        @(posedge clk);
        #1;
        if (uart_tx === 1'b0 && !rst) begin
            s = cyc;
            repeat (BITC / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BITC) @(posedge clk);
                #1;
                b[i] = uart_tx;
            end
            repeat (BITC) @(posedge clk);
            #1;
            check("tx_stop", uart_tx, 1);
            tx_q.push_back(b);
            st_q.push_back(s);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        uart_rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BITC) @(negedge clk);
        end
        uart_rx = !bad_stop;
        repeat (BITC) @(negedge clk);
        uart_rx = 1'b1;
        repeat (BITC) @(negedge clk);
    endtask

    task automatic run_req(input logic [7:0] cmd, input logic [63:0] data, input logic [63:0] reply,
                           input int bad, input bit silent);
        bit rep;
        int n0, t;
        logic [1:0] exp_e;
        logic [63:0] exp_d;
        rep = cmd == 8'h0F || cmd == 8'hF0;
        tx_q.delete();
        st_q.delete();
        n0 = rsp_cnt;
        @(negedge clk);
        check("ready", req_ready, 1);
        req_valid = 1'b1;
        req_cmd = cmd;
        req_data = data;
        @(negedge clk);
        req_valid = 1'b0;
        req_cmd = 8'($urandom);
        req_data = {$urandom, $urandom};
        check("start_low", uart_tx, 0);
        check("busy", busy, 1);
        t = 0;
        while (tx_q.size() < 9 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        check("tx_bytes", tx_q.size(), 9);
        for (int i = 0; i < tx_q.size() && i < 9; i++) begin
            check($sformatf("tx_byte%0d", i), tx_q[i], i == 0 ? cmd : data[8*(8-i) +: 8]);
            if (i > 0) check($sformatf("tx_space%0d", i), st_q[i] - st_q[i-1], 176);
        end
        if (rep && !silent) begin
            repeat (40) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                send_byte(reply[8*(7-k) +: 8], k == bad);
                if (k == bad) break;
            end
        end
`ifndef DES_HOST_TIMEOUT_EN
        if (silent) begin
            repeat (400) @(posedge clk);
            check("silent_no_rsp", rsp_cnt - n0, 0);
            check("silent_busy", busy, 1);
            return;
        end
`endif
        t = 0;
        while (rsp_cnt == n0 && t < 6000) begin
            @(posedge clk);
            t++;
        end
        check("rsp_count", rsp_cnt - n0, 1);
        exp_e = silent ? 2'b10 : (rep && bad >= 0) ? 2'b01 : 2'b00;
        exp_d = exp_e != 2'b00 ? model_data : rep ? reply : 64'd0;
        check("rsp_err", rsp_e_cap, exp_e);
        check("rsp_data", rsp_d_cap, exp_d);
        if (!rep && st_q.size() == 9) check("rsp_latency", rsp_cyc - st_q[8], 176);
        if (silent && st_q.size() == 9) check("timeout_latency", rsp_cyc - st_q[8], 240);
        model_data = exp_d;
        @(negedge clk);
        check("busy_after", busy, 0);
        check("valid_after", rsp_valid, 0);
        check("data_held", rsp_data, exp_d);
    endtask

    initial begin
        int n0, t, sel;
        logic [7:0] cmd;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_valid", rsp_valid, 0);
        check("rst_data", rsp_data, 0);
        check("rst_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_tx", uart_tx, 1);
        rst = 1'b0;
        run_req(8'hFF, 64'h133457799BBCDFF1, 64'd0, -1, 1'b0);
        run_req(8'h0F, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, -1, 1'b0);
        run_req(8'hF0, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, -1, 1'b0);
        run_req(8'h0F, {$urandom, $urandom}, {$urandom, $urandom}, 2, 1'b0);
        run_req(8'hF0, {$urandom, $urandom}, 64'd0, -1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_data = 64'd0;
        tx_q.delete();
        st_q.delete();
        n0 = rsp_cnt;
        req_valid = 1'b1;
        req_cmd = 8'h0F;
        req_data = {$urandom, $urandom};
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (tx_q.size() < 3 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("pre_rst_bytes", tx_q.size(), 3);
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", uart_tx, 1);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rsp_valid, 0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("mid_rst_no_rsp", rsp_cnt - n0, 0);
        check("mid_rst_data", rsp_data, 0);
        for (int i = 0; i < 4; i++) begin
            sel = $urandom_range(0, 3);
            cmd = sel == 0 ? 8'hFF : sel == 1 ? 8'h0F : sel == 2 ? 8'hF0 : 8'($urandom);
            run_req(cmd, {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 7)) : -1, 1'b0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #950_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
